// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle main controller (master) and the datapath (slave).
interface mc_controller_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       pcwrite;
  logic       branch;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       alu_force_add;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready, branch_taken,
    output mem_req, iord, irwrite, memwrite, pcwrite, branch, pcen, pcsrc, alusrca, alusrcb,
           alu_force_add, regdst, memtoreg, regwrite, illegal_op, state
  );

  modport slave (
    output op, mem_ready, branch_taken,
    input  mem_req, iord, irwrite, memwrite, pcwrite, branch, pcen, pcsrc, alusrca, alusrcb,
           alu_force_add, regdst, memtoreg, regwrite, illegal_op, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MC_JUMP_EN to enable the JUMP state for op 000010 (otherwise that op is illegal).
module mc_controller (
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10
`ifdef MC_JUMP_EN
    ,
    StJump    = 4'd11
`endif
  } state_e;

  state_e state_q, state_d, out_state;

  logic is_lw, is_sw, is_rtype, is_branch, is_imm, is_jump, is_legal;

  assign is_lw     = (bus.op == 6'b100011);
  assign is_sw     = (bus.op == 6'b101011);
  assign is_rtype  = (bus.op == 6'b000000);
  assign is_branch = (bus.op == 6'b000001) || (bus.op == 6'b000011) || (bus.op[5:2] == 4'b0001);
  assign is_imm    = (bus.op == 6'b001000) || (bus.op == 6'b001010) ||
                     (bus.op == 6'b001100) || (bus.op == 6'b001101);
`ifdef MC_JUMP_EN
  assign is_jump   = (bus.op == 6'b000010);
`else
  assign is_jump   = 1'b0;
`endif
  assign is_legal  = is_lw || is_sw || is_rtype || is_branch || is_imm || is_jump;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (is_lw || is_sw)  state_d = StMemAdr;
        else if (is_rtype)   state_d = StRtypeEx;
        else if (is_branch)  state_d = StBranch;
        else if (is_imm)     state_d = StImmEx;
`ifdef MC_JUMP_EN
        else if (is_jump)    state_d = StJump;
`endif
        else                 state_d = StFetch;
      end
      StMemAdr:  state_d = is_sw ? StMemWr : StMemRd;
      StMemRd:   state_d = bus.mem_ready ? StMemWb : StMemRd;
      StMemWr:   state_d = bus.mem_ready ? StFetch : StMemWr;
      StRtypeEx: state_d = StAluWb;
      StImmEx:   state_d = StImmWb;
      default:   state_d = StFetch;
    endcase
  end

  logic       mem_req, iord, irwrite, memwrite, pcwrite, branch;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca, alu_force_add, regdst, memtoreg, regwrite, illegal_op;

  // Under reset the muxes present FETCH selects and every strobe is cleared.
  assign out_state = reset ? StFetch : state_q;

  always_comb begin
    mem_req       = 1'b0;
    iord          = 1'b0;
    irwrite       = 1'b0;
    memwrite      = 1'b0;
    pcwrite       = 1'b0;
    branch        = 1'b0;
    pcsrc         = 2'b00;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    alu_force_add = 1'b0;
    regdst        = 1'b0;
    memtoreg      = 1'b0;
    regwrite      = 1'b0;
    illegal_op    = 1'b0;
    case (out_state)
      StFetch: begin
        mem_req       = 1'b1;
        alusrcb       = 2'b01;
        alu_force_add = 1'b1;
        irwrite       = bus.mem_ready;
        pcwrite       = bus.mem_ready;
      end
      StDecode: begin
        alusrcb       = 2'b11;
        alu_force_add = 1'b1;
        illegal_op    = ~is_legal;
      end
      StMemAdr: begin
        alusrca       = 1'b1;
        alusrcb       = 2'b10;
        alu_force_add = 1'b1;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: alusrca = 1'b1;
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBranch: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      StImmEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StImmWb: regwrite = 1'b1;
`ifdef MC_JUMP_EN
      StJump: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign bus.mem_req       = mem_req;
  assign bus.iord          = iord;
  assign bus.irwrite       = irwrite;
  assign bus.memwrite      = memwrite;
  assign bus.pcwrite       = pcwrite;
  assign bus.branch        = branch;
  assign bus.pcen          = pcwrite | (branch & bus.branch_taken);
  assign bus.pcsrc         = pcsrc;
  assign bus.alusrca       = alusrca;
  assign bus.alusrcb       = alusrcb;
  assign bus.alu_force_add = alu_force_add;
  assign bus.regdst        = regdst;
  assign bus.memtoreg      = memtoreg;
  assign bus.regwrite      = regwrite;
  assign bus.illegal_op    = illegal_op;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction table, corner sequences, random run.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

`ifdef MC_JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  typedef struct packed {
    logic       mem_req, iord, irwrite, memwrite, pcwrite, branch, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       alu_force_add, regdst, memtoreg, regwrite, illegal_op;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       taken;
    int         waits;
    int         exp_cycles;
    logic [15:0] exp_visit;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int m_state;
  int m_plan[$];

  function automatic bit op_legal(input logic [5:0] op);
    return (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000001, 6'b000011,
                       [6'b000100 : 6'b000111], 6'b001000, 6'b001010, 6'b001100, 6'b001101})
           || (JumpEn && op == 6'b000010);
  endfunction

  // Remaining steps of an instruction after DECODE.
  task automatic load_plan(input logic [5:0] op);
    m_plan.delete();
    if (op == 6'b100011) m_plan = '{2, 3, 4};
    else if (op == 6'b101011) m_plan = '{2, 5};
    else if (op == 6'b000000) m_plan = '{6, 7};
    else if (op inside {6'b000001, 6'b000011, [6'b000100 : 6'b000111]}) m_plan = '{8};
    else if (op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101}) m_plan = '{9, 10};
    else if (JumpEn && op == 6'b000010) m_plan = '{11};
  endtask

  function automatic outs_t expect_outs(input int s, input logic [5:0] op, input logic rdy,
                                        input logic bt, input logic rst);
    outs_t e = '0;
    int v = rst ? 0 : s;
    case (v)
      0: begin
        e.mem_req = 1; e.alusrcb = 2'b01; e.alu_force_add = 1; e.irwrite = rdy; e.pcwrite = rdy;
      end
      1: begin e.alusrcb = 2'b11; e.alu_force_add = 1; e.illegal_op = !op_legal(op); end
      2: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alu_force_add = 1; end
      3: begin e.mem_req = 1; e.iord = 1; end
      4: begin e.regwrite = 1; e.memtoreg = 1; end
      5: begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; end
      6: e.alusrca = 1;
      7: begin e.regwrite = 1; e.regdst = 1; end
      8: begin e.alusrca = 1; e.branch = 1; e.pcsrc = 2'b01; end
      9: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcwrite = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      e.mem_req = 0; e.irwrite = 0; e.pcwrite = 0;
    end
    e.pcen  = e.pcwrite | (e.branch & bt);
    e.state = 4'(s);
    return e;
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle(input string name);
    outs_t got, exp;
    @(negedge clk);
    got = {bus.mem_req, bus.iord, bus.irwrite, bus.memwrite, bus.pcwrite, bus.branch, bus.pcen,
           bus.pcsrc, bus.alusrca, bus.alusrcb, bus.alu_force_add, bus.regdst, bus.memtoreg,
           bus.regwrite, bus.illegal_op, bus.state};
    exp = expect_outs(m_state, bus.op, bus.mem_ready, bus.branch_taken, reset);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t outputs got=%h expected=%h", name, $time, got, exp);
    end
    if (reset) begin
      m_state = 0;
      m_plan.delete();
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !bus.mem_ready) begin
      m_state = m_state;
    end else if (m_state == 0) begin
      m_state = 1;
      load_plan(bus.op);
    end else if (m_plan.size() > 0) begin
      m_state = m_plan.pop_front();
    end else begin
      m_state = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    int waits = v.waits;
    int n = 0;
    bit done = 0;
    logic [15:0] visit = '0;
    bus.op = v.op;
    bus.branch_taken = v.taken;
    reset = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      bus.mem_ready = ((m_state == 3 || m_state == 5) && waits > 0) ? 1'b0 : 1'b1;
      if (!bus.mem_ready) waits--;
      if (!$isunknown(bus.state)) visit[bus.state] = 1'b1;
      n++;
      cycle(v.name);
      if (bus.state == 4'd0) done = 1;
    end
    checks++;
    if (!done || n != v.exp_cycles) begin
      failures++;
      $display("FAIL %s cycles got=%0d expected=%0d", v.name, n, v.exp_cycles);
    end
    checks++;
    if (visit !== v.exp_visit) begin
      failures++;
      $display("FAIL %s visited got=%h expected=%h", v.name, visit, v.exp_visit);
    end
  endtask

  vec_t vecs[11];
  logic [5:0] op_pool[13];

  initial begin
    vecs[0]  = '{"rtype",     6'b000000, 1'b0, 0, 4, 16'h00C3};
    vecs[1]  = '{"lw_wait2",  6'b100011, 1'b0, 2, 7, 16'h001F};
    vecs[2]  = '{"lw",        6'b100011, 1'b0, 0, 5, 16'h001F};
    vecs[3]  = '{"sw_wait1",  6'b101011, 1'b0, 1, 5, 16'h0027};
    vecs[4]  = '{"addi",      6'b001000, 1'b0, 0, 4, 16'h0603};
    vecs[5]  = '{"ori",       6'b001101, 1'b0, 0, 4, 16'h0603};
    vecs[6]  = '{"beq_taken", 6'b000100, 1'b1, 0, 3, 16'h0103};
    vecs[7]  = '{"bltz_nt",   6'b000001, 1'b0, 0, 3, 16'h0103};
    vecs[8]  = '{"jal_br",    6'b000011, 1'b1, 0, 3, 16'h0103};
    vecs[9]  = '{"illegal",   6'b111111, 1'b0, 0, 2, 16'h0003};
    if (JumpEn) vecs[10] = '{"jump", 6'b000010, 1'b0, 0, 3, 16'h0803};
    else        vecs[10] = '{"jump", 6'b000010, 1'b0, 0, 2, 16'h0003};

    op_pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000001, 6'b000011, 6'b000100, 6'b000111,
                6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010, 6'b111111};

    // Reset held three checked cycles with memory ready.
    reset = 1; bus.op = 6'b000000; bus.mem_ready = 1; bus.branch_taken = 0;
    @(posedge clk);
    #1;
    m_state = 0;
    for (int i = 0; i < 3; i++) cycle("reset_hold");

    foreach (vecs[i]) run_instr(vecs[i]);

    // Reset asserted while a store is waiting in MEMWR.
    reset = 0; bus.op = 6'b101011; bus.mem_ready = 1;
    for (int i = 0; i < 10 && m_state != 5; i++) cycle("sw_to_memwr");
    reset = 1; bus.mem_ready = 0;
    @(negedge clk);
    checks++;
    if (bus.memwrite !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_memwr memwrite=%b mem_req=%b expected 0 0",
               bus.memwrite, bus.mem_req);
    end
    @(posedge clk);
    #1;
    m_state = 0;
    m_plan.delete();
    reset = 0; bus.mem_ready = 1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL reset_in_memwr_state got=%0d expected=0", bus.state);
    end

    // Random run against the model.
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        int k = $urandom_range(0, 13);
        bus.op = (k == 13) ? 6'($urandom) : op_pool[k];
      end
      bus.mem_ready    = ($urandom_range(0, 3) != 0);
      bus.branch_taken = 1'($urandom);
      reset            = ($urandom_range(0, 59) == 0);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
